// File: rtl/a2rt_pkg.sv
// a2rt_pkg: shared types and constants for the ASCII-art renderer front end.
//   cond_state_t  - line conditioner FSM states
//   A2RT_*        - default geometry / pixel width and statistics counter width
//   cnt_w()       - width of a counter covering [0, n-1] (minimum 1 bit)
//   sat_inc()     - saturating increment for the statistics counters
package a2rt_pkg;

  typedef enum logic [2:0] {
    WAIT_SOF,
    PASS,
    PAD_LINE,
    DROP_LINE,
    PAD_FRAME
  } cond_state_t;

  localparam int A2RT_DATA_WIDTH    = 24;
  localparam int A2RT_SCREEN_WIDTH  = 800;
  localparam int A2RT_SCREEN_HEIGHT = 600;

  localparam int                     A2RT_STAT_W   = 16;
  localparam logic [A2RT_STAT_W-1:0] A2RT_STAT_MAX = '1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [A2RT_STAT_W-1:0] sat_inc(input logic [A2RT_STAT_W-1:0] v,
                                                     input logic                   en);
    return (en && (v != A2RT_STAT_MAX)) ? v + A2RT_STAT_W'(1) : v;
  endfunction

endpackage

// File: rtl/a2rt_stream_reg.sv
// a2rt_stream_reg: single-stage valid/ready register carrying {sof, eow, pixel}.
// Loads whenever it is free (empty, or its current beat is being taken), so it
// sustains one beat per clock with one cycle of latency. Once o_vld is high the
// beat is held unchanged until i_rdy accepts it.
//   clk, rst_n      clock, asynchronous active-low reset
//   i_vld/i_sof/i_eow/i_pix   beat offered by the producer (taken when o_free)
//   o_free          stage can take a beat this cycle
//   o_vld/o_sof/o_eow/o_pix   registered beat towards the consumer
//   i_rdy           consumer ready
module a2rt_stream_reg #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_vld,
  input  logic                  i_sof,
  input  logic                  i_eow,
  input  logic [DATA_WIDTH-1:0] i_pix,
  output logic                  o_free,
  output logic                  o_vld,
  output logic                  o_sof,
  output logic                  o_eow,
  output logic [DATA_WIDTH-1:0] o_pix,
  input  logic                  i_rdy
);

  logic                  r_vld;
  logic                  r_sof;
  logic                  r_eow;
  logic [DATA_WIDTH-1:0] r_pix;

  assign o_free = ~r_vld | i_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_sof <= 1'b0;
      r_eow <= 1'b0;
      r_pix <= '0;
    end else if (o_free) begin
      r_vld <= i_vld;
      // Side-band flags are cleared on an empty load so they never linger
      // next to a deasserted valid.
      r_sof <= i_vld & i_sof;
      r_eow <= i_vld & i_eow;
      if (i_vld) r_pix <= i_pix;
    end
  end

  assign o_vld = r_vld;
  assign o_sof = r_sof;
  assign o_eow = r_eow;
  assign o_pix = r_pix;

endmodule

// File: rtl/a2rt_line_conditioner.sv
// a2rt_line_conditioner: forces the raw pixel stream into exact screen geometry
// (SCREEN_WIDTH pixels per line, SCREEN_HEIGHT lines per frame, first pixel on
// SOF). Short lines/frames are padded with PAD_PIXEL, long lines are truncated,
// beats before the first SOF are discarded.
//   clk, rst_n                  clock, asynchronous active-low reset
//   rts_i/rtr_o/sof_i/eow_i/pixel_i   raw input stream
//   rts_o/rtr_i/sof_o/eow_o/pixel_o   conditioned output stream (1-cycle latency)
//   short_line_cnt/long_line_cnt/early_sof_cnt  saturating event counters
// Build option: define A2RT_COND_STATS_EN to enable the event counters; without
// it the counter ports are tied to zero.
module a2rt_line_conditioner
  import a2rt_pkg::*;
#(
  parameter int                    DATA_WIDTH    = A2RT_DATA_WIDTH,
  parameter int                    SCREEN_WIDTH  = A2RT_SCREEN_WIDTH,
  parameter int                    SCREEN_HEIGHT = A2RT_SCREEN_HEIGHT,
  parameter logic [DATA_WIDTH-1:0] PAD_PIXEL     = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rts_i,
  output logic                   rtr_o,
  input  logic                   sof_i,
  input  logic                   eow_i,
  input  logic [DATA_WIDTH-1:0]  pixel_i,
  output logic                   rts_o,
  input  logic                   rtr_i,
  output logic                   sof_o,
  output logic                   eow_o,
  output logic [DATA_WIDTH-1:0]  pixel_o,
  output logic [A2RT_STAT_W-1:0] short_line_cnt,
  output logic [A2RT_STAT_W-1:0] long_line_cnt,
  output logic [A2RT_STAT_W-1:0] early_sof_cnt
);

  localparam int             XW     = cnt_w(SCREEN_WIDTH);
  localparam int             YW     = cnt_w(SCREEN_HEIGHT);
  localparam logic [XW-1:0]  X_LAST = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST = YW'(SCREEN_HEIGHT - 1);

  cond_state_t           r_state;
  cond_state_t           w_state_nxt;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;

  logic                  w_free;
  logic                  w_last_x;
  logic                  w_last_y;
  logic                  w_at_origin;
  logic                  w_rtr;
  logic                  w_pass_beat;
  logic                  w_ld;
  logic [DATA_WIDTH-1:0] w_ld_pix;

  assign w_last_x    = (r_x == X_LAST);
  assign w_last_y    = (r_y == Y_LAST);
  assign w_at_origin = (r_x == '0) && (r_y == '0);

  // Next-state / emit decision. Every emitted beat (real or pad) advances x/y,
  // so sof_o and eow_o fall straight out of the current position.
  always_comb begin
    w_state_nxt = r_state;
    w_rtr       = 1'b0;
    w_pass_beat = 1'b0;
    w_ld        = 1'b0;
    w_ld_pix    = PAD_PIXEL;
    unique case (r_state)
      WAIT_SOF: begin
        // Pre-SOF garbage is always swallowed; only the SOF beat waits for room.
        w_rtr       = ~sof_i | w_free;
        w_pass_beat = rts_i & sof_i & w_free;
      end
      PASS: begin
        // A SOF here is never at (0,0): hold it off and pad out the frame.
        w_rtr = w_free & ~sof_i;
        if (rts_i && sof_i) w_state_nxt = PAD_FRAME;
        else                w_pass_beat = rts_i & w_free;
      end
      PAD_LINE: begin
        w_ld = w_free;
        if (w_free && w_last_x) w_state_nxt = w_last_y ? WAIT_SOF : PASS;
      end
      DROP_LINE: begin
        // x is already 0 here; y == 0 means the truncated line closed the frame.
        w_rtr = ~sof_i;
        if (rts_i && (sof_i || eow_i)) begin
          if (w_at_origin) w_state_nxt = WAIT_SOF;
          else             w_state_nxt = sof_i ? PAD_FRAME : PASS;
        end
      end
      PAD_FRAME: begin
        w_ld = w_free;
        if (w_free && w_last_x && w_last_y) w_state_nxt = WAIT_SOF;
      end
      default: w_state_nxt = WAIT_SOF;
    endcase

    if (w_pass_beat) begin
      w_ld     = 1'b1;
      w_ld_pix = pixel_i;
      if (eow_i && !w_last_x)      w_state_nxt = PAD_LINE;
      else if (w_last_x && !eow_i) w_state_nxt = DROP_LINE;
      else if (w_last_x && w_last_y) w_state_nxt = WAIT_SOF;
      else                         w_state_nxt = PASS;
    end
  end

  assign rtr_o = w_rtr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_SOF;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld) begin
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last_y ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

  a2rt_stream_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_ld),
    .i_sof  (w_at_origin),
    .i_eow  (w_last_x),
    .i_pix  (w_ld_pix),
    .o_free (w_free),
    .o_vld  (rts_o),
    .o_sof  (sof_o),
    .o_eow  (eow_o),
    .o_pix  (pixel_o),
    .i_rdy  (rtr_i)
  );

`ifdef A2RT_COND_STATS_EN
  logic                   w_ev_short;
  logic                   w_ev_long;
  logic                   w_ev_early;
  logic [A2RT_STAT_W-1:0] r_short_cnt;
  logic [A2RT_STAT_W-1:0] r_long_cnt;
  logic [A2RT_STAT_W-1:0] r_early_cnt;

  // Each event coincides with the one-cycle transition into its handling state.
  assign w_ev_short = w_pass_beat & eow_i & ~w_last_x;
  assign w_ev_long  = w_pass_beat & ~eow_i & w_last_x;
  assign w_ev_early = rts_i & sof_i &
                      ((r_state == PASS) | ((r_state == DROP_LINE) & ~w_at_origin));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_short_cnt <= '0;
      r_long_cnt  <= '0;
      r_early_cnt <= '0;
    end else begin
      r_short_cnt <= sat_inc(r_short_cnt, w_ev_short);
      r_long_cnt  <= sat_inc(r_long_cnt,  w_ev_long);
      r_early_cnt <= sat_inc(r_early_cnt, w_ev_early);
    end
  end

  assign short_line_cnt = r_short_cnt;
  assign long_line_cnt  = r_long_cnt;
  assign early_sof_cnt  = r_early_cnt;
`else
  assign short_line_cnt = '0;
  assign long_line_cnt  = '0;
  assign early_sof_cnt  = '0;
`endif

endmodule
